// File: rtl/fluxo_dados_pkg.sv
// Shared constants for the memory-sequence game datapath: default widths and the
// stored button sequence.
package fluxo_dados_pkg;

    localparam int unsigned N_ADDR_DEF = 4;
    localparam int unsigned N_DATA_DEF = 4;

    localparam logic [3:0] ROM_W00 = 4'b0001;
    localparam logic [3:0] ROM_W01 = 4'b0010;
    localparam logic [3:0] ROM_W02 = 4'b0100;
    localparam logic [3:0] ROM_W03 = 4'b1000;
    localparam logic [3:0] ROM_W04 = 4'b0100;
    localparam logic [3:0] ROM_W05 = 4'b0010;
    localparam logic [3:0] ROM_W06 = 4'b0001;
    localparam logic [3:0] ROM_W07 = 4'b0001;
    localparam logic [3:0] ROM_W08 = 4'b0010;
    localparam logic [3:0] ROM_W09 = 4'b0010;
    localparam logic [3:0] ROM_W10 = 4'b0100;
    localparam logic [3:0] ROM_W11 = 4'b0100;
    localparam logic [3:0] ROM_W12 = 4'b1000;
    localparam logic [3:0] ROM_W13 = 4'b1000;
    localparam logic [3:0] ROM_W14 = 4'b0001;
    localparam logic [3:0] ROM_W15 = 4'b0100;

    function automatic logic [3:0] rom_read(input logic [3:0] addr);
        case (addr)
            4'd0:    rom_read = ROM_W00;
            4'd1:    rom_read = ROM_W01;
            4'd2:    rom_read = ROM_W02;
            4'd3:    rom_read = ROM_W03;
            4'd4:    rom_read = ROM_W04;
            4'd5:    rom_read = ROM_W05;
            4'd6:    rom_read = ROM_W06;
            4'd7:    rom_read = ROM_W07;
            4'd8:    rom_read = ROM_W08;
            4'd9:    rom_read = ROM_W09;
            4'd10:   rom_read = ROM_W10;
            4'd11:   rom_read = ROM_W11;
            4'd12:   rom_read = ROM_W12;
            4'd13:   rom_read = ROM_W13;
            4'd14:   rom_read = ROM_W14;
            default: rom_read = ROM_W15;
        endcase
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse the first clock edge after sinal goes high.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic s1;
    logic s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sinal;
            s2 <= s1;
        end
    end

    assign pulso = s1 & ~s2;

endmodule

// File: rtl/fluxo_dados.sv
// Datapath for the memory-sequence game: address counter, move register, sequence ROM,
// comparator and button edge detector, driven by the control unit's commands.
module fluxo_dados
    import fluxo_dados_pkg::*;
#(
    parameter int unsigned N_ADDR = N_ADDR_DEF,
    parameter int unsigned N_DATA = N_DATA_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              zeraC,
    input  logic              contaC,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic [N_DATA-1:0] botoes,
    output logic              igual,
    output logic              fim,
    output logic              jogada_feita,
    output logic              db_tem_jogada,
    output logic [N_ADDR-1:0] db_contagem,
    output logic [N_DATA-1:0] db_memoria,
    output logic [N_DATA-1:0] db_jogada
);

    logic [N_ADDR-1:0] contagem;
    logic [N_DATA-1:0] jogada;
    logic [N_DATA-1:0] memoria;
    logic              tem_jogada;

    // Clear wins over count; the counter wraps naturally at 2^N_ADDR.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zeraC) begin
            contagem <= '0;
        end else if (contaC) begin
            contagem <= contagem + N_ADDR'(1);
        end
    end

    // Clear wins over load; multi-bit button values are stored unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada <= '0;
        end else if (zeraR) begin
            jogada <= '0;
        end else if (registraR) begin
            jogada <= botoes;
        end
    end

    assign memoria    = N_DATA'(rom_read(4'(contagem)));
    assign tem_jogada = |botoes;

    edge_detector u_edge_detector (
        .clock (clock),
        .reset (reset),
        .sinal (tem_jogada),
        .pulso (jogada_feita)
    );

    assign igual         = (jogada == memoria);
    assign fim           = (contagem == {N_ADDR{1'b1}});
    assign db_tem_jogada = tem_jogada;
    assign db_contagem   = contagem;
    assign db_memoria    = memoria;
    assign db_jogada     = jogada;

endmodule

// File: tb/tb_fluxo_dados.sv
// Self-checking bench for fluxo_dados: directed table, corner sequences and a
// randomized run against a behavioural model.
module tb_fluxo_dados;

    logic       clock;
    logic       reset;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic [3:0] botoes;
    logic       igual;
    logic       fim;
    logic       jogada_feita;
    logic       db_tem_jogada;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_jogada;

    int tests;
    int fails;

    fluxo_dados dut (
        .clock         (clock),
        .reset         (reset),
        .zeraC         (zeraC),
        .contaC        (contaC),
        .zeraR         (zeraR),
        .registraR     (registraR),
        .botoes        (botoes),
        .igual         (igual),
        .fim           (fim),
        .jogada_feita  (jogada_feita),
        .db_tem_jogada (db_tem_jogada),
        .db_contagem   (db_contagem),
        .db_memoria    (db_memoria),
        .db_jogada     (db_jogada)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sequence as written in the game description.
    logic [3:0] seq_ref [16];

    typedef struct {
        logic [3:0] botoes;
        logic       exp_igual;
        logic [3:0] exp_mem;
        logic       exp_fim;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int actual, input int required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
    endtask

    // Behavioural model state
    int         m_cnt;
    logic [3:0] m_reg;
    logic       m_now;
    logic       m_prev;

    initial begin
        tests = 0;
        fails = 0;
        seq_ref = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                    4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
        vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
        vecs[1]  = '{4'b0100, 1'b0, 4'b0010, 1'b0};
        vecs[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b0};
        vecs[3]  = '{4'b1000, 1'b1, 4'b1000, 1'b0};
        vecs[4]  = '{4'b0001, 1'b0, 4'b0100, 1'b0};
        vecs[5]  = '{4'b0010, 1'b1, 4'b0010, 1'b0};
        vecs[6]  = '{4'b0001, 1'b1, 4'b0001, 1'b0};
        vecs[7]  = '{4'b0011, 1'b0, 4'b0001, 1'b0};
        vecs[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b0};
        vecs[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b0};
        vecs[10] = '{4'b0100, 1'b1, 4'b0100, 1'b0};
        vecs[11] = '{4'b1000, 1'b0, 4'b0100, 1'b0};
        vecs[12] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
        vecs[13] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
        vecs[14] = '{4'b0001, 1'b1, 4'b0001, 1'b0};
        vecs[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1};

        // Reset state
        reset  = 1'b1;
        botoes = 4'b0000;
        idle_inputs();
        repeat (2) tick();
        check("rst_contagem", db_contagem, 0);
        check("rst_jogada", db_jogada, 0);
        check("rst_memoria", db_memoria, 4'b0001);
        check("rst_igual", igual, 0);
        check("rst_fim", fim, 0);
        check("rst_pulse", jogada_feita, 0);
        check("rst_tem", db_tem_jogada, 0);
        reset = 1'b0;
        tick();

        // Held press: exactly one pulse, one edge after the press
        botoes = 4'b0001;
        #1 check("tem_jogada_on", db_tem_jogada, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("press1_cyc%0d", i), jogada_feita, (i == 0) ? 1 : 0);
        end
        botoes = 4'b0000;
        repeat (2) tick();
        check("release_pulse", jogada_feita, 0);
        botoes = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("press2_cyc%0d", i), jogada_feita, (i == 0) ? 1 : 0);
        end
        botoes = 4'b0000;

        // Table: register a move at each address and compare against the sequence
        for (int a = 0; a < 16; a++) begin
            registraR = 1'b1;
            botoes    = vecs[a].botoes;
            tick();
            registraR = 1'b0;
            botoes    = 4'b0000;
            check($sformatf("tbl%0d_contagem", a), db_contagem, a);
            check($sformatf("tbl%0d_jogada", a), db_jogada, vecs[a].botoes);
            check($sformatf("tbl%0d_memoria", a), db_memoria, vecs[a].exp_mem);
            check($sformatf("tbl%0d_igual", a), igual, vecs[a].exp_igual);
            check($sformatf("tbl%0d_fim", a), fim, vecs[a].exp_fim);
            if (a < 15) begin
                contaC = 1'b1;
                tick();
                contaC = 1'b0;
            end
        end

        // Wrap from 15 to 0
        contaC = 1'b1;
        tick();
        contaC = 1'b0;
        check("wrap_contagem", db_contagem, 0);
        check("wrap_fim", fim, 0);
        check("wrap_memoria", db_memoria, 4'b0001);

        // Counter priority at count 7
        contaC = 1'b1;
        repeat (7) tick();
        check("pre_prio_contagem", db_contagem, 7);
        zeraC = 1'b1;
        tick();
        idle_inputs();
        check("prio_zeraC", db_contagem, 0);

        // Register priority
        registraR = 1'b1;
        botoes    = 4'b0001;
        tick();
        check("pre_prio_jogada", db_jogada, 4'b0001);
        zeraR  = 1'b1;
        botoes = 4'b1000;
        tick();
        idle_inputs();
        botoes = 4'b0000;
        check("prio_zeraR", db_jogada, 0);

        // Asynchronous reset mid-cycle at count 9
        contaC = 1'b1;
        repeat (9) tick();
        contaC = 1'b0;
        check("pre_arst_contagem", db_contagem, 9);
        #2 reset = 1'b1;
        #1 check("arst_contagem", db_contagem, 0);
        check("arst_fim", fim, 0);
        botoes = 4'b0100;
        #2 reset = 1'b0;
        tick();
        check("arst_press_pulse", jogada_feita, 1);
        tick();
        check("arst_press_hold", jogada_feita, 0);
        botoes = 4'b0000;

        // Randomized run against the behavioural model
        reset = 1'b1;
        idle_inputs();
        tick();
        reset  = 1'b0;
        m_cnt  = 0;
        m_reg  = 4'b0000;
        m_now  = 1'b0;
        m_prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            int sel;
            zeraC     = ($urandom_range(0, 15) == 0);
            contaC    = ($urandom_range(0, 1) == 1);
            zeraR     = ($urandom_range(0, 11) == 0);
            registraR = ($urandom_range(0, 2) == 0);
            sel       = $urandom_range(0, 9);
            if (sel < 4)       botoes = 4'b0000;
            else if (sel < 9)  botoes = 4'(1 << $urandom_range(0, 3));
            else               botoes = 4'($urandom_range(0, 15));
            #1 check("rnd_tem", db_tem_jogada, (botoes != 0) ? 1 : 0);
            tick();
            if (zeraC)       m_cnt = 0;
            else if (contaC) m_cnt = (m_cnt + 1) % 16;
            if (zeraR)          m_reg = 4'b0000;
            else if (registraR) m_reg = botoes;
            m_prev = m_now;
            m_now  = (botoes != 0);
            check("rnd_contagem", db_contagem, m_cnt);
            check("rnd_jogada", db_jogada, m_reg);
            check("rnd_memoria", db_memoria, seq_ref[m_cnt]);
            check("rnd_igual", igual, (m_reg == seq_ref[m_cnt]) ? 1 : 0);
            check("rnd_fim", fim, (m_cnt == 15) ? 1 : 0);
            check("rnd_pulse", jogada_feita, (m_now && !m_prev) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fluxo_dados.md
# fluxo_dados

Datapath for the memory-sequence game in Experiment 4. It sits directly under `unidade_controle` and executes that block's commands:
- `zeraC`/`contaC` drive the address counter.
- `zeraR`/`registraR` drive the move register.

It returns `fim`, `igual` and a one-cycle `jogada_feita` pulse, which the control unit consumes as `fim`, `igual` and `jogada`. The block holds the 16-entry stored sequence, a 4-bit address counter, the player-move register and a button edge detector.

## Interface
- `N_ADDR`, default 4: address width; sequence depth is 2^N_ADDR.
- `N_DATA`, default 4: data width; one bit per button.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `zeraC`  in  1  synchronous clear of the address counter.
- `contaC`  in  1  increment address counter.
- `zeraR`  in  1  synchronous clear of the move register.
- `registraR`  in  1  load `botoes` into the move register.
- `botoes`  in  N_DATA  player buttons, level, one-hot when valid.
- `igual`  out  1  move register equals memory word at current address.
- `fim`  out  1  counter equals 2^N_ADDR-1.
- `jogada_feita`  out  1  single-cycle pulse on button press.
- `db_tem_jogada`  out  1  OR of `botoes`, unregistered.
- `db_contagem`  out  N_ADDR  current counter value.
- `db_memoria`  out  N_DATA  memory word at current address.
- `db_jogada`  out  N_DATA  move register contents.

## Operation
- **Counter.**
  - `zeraC` has priority and sets the counter to 0.
  - Otherwise, `contaC` increments it. It wraps from 15 to 0 with no flag beyond `fim`.
  - With neither asserted, it holds.
- **Move register.**
  - `zeraR` has priority and sets the register to 0.
  - Otherwise, `registraR` loads `botoes`.
  - With neither asserted, it holds.
  - Contents are not checked for one-hot; a multi-bit value is stored as is.
- **Memory.** 16x4 ROM with combinational read, addressed by the counter. Contents for addresses 0..15:
  - 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001
  - 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100
- **Comparator.** `igual` = (move register == memory word), evaluated combinationally.
- **Edge detector.**
  - `tem_jogada` = OR(`botoes`).
  - Two flops: s1 <= tem_jogada, s2 <= s1.
  - `jogada_feita` = s1 & ~s2.
  - A held button gives exactly one pulse. A new pulse requires release (tem_jogada = 0 for at least one sampled cycle) followed by a press.

## Timing
- Reset values:
  - counter = 0, move register = 0, s1 = s2 = 0.
  - Hence `fim` = 0, `db_contagem` = 0, `db_jogada` = 0, `jogada_feita` = 0, `db_memoria` = 0001.
  - `igual` = 0, because 0000 ≠ 0001.
- Reset mid-operation clears all state immediately, regardless of the clock.
- `jogada_feita` rises on the first clock edge after `botoes` goes nonzero. It stays high for exactly one cycle.
- A button held across reset release produces one pulse after the first edge.
- `igual`, `fim` and `db_memoria` are valid the same cycle the counter or register changes; there is no extra latency.
- Simultaneous `zeraC` and `contaC`: the counter goes to 0.
- Simultaneous `zeraR` and `registraR`: the register goes to 0.
- With the control unit's sequence (registra, then compara), `igual` is valid in the `compara` state. This holds because `registraR` loads at the end of `registra`.

## Structure
- Shared package/include holds:
  - N_ADDR and N_DATA defaults.
  - The 16 ROM words as named constants.
- Natural sub-module: `edge_detector` (clock, reset, sinal -> pulso), reused by later experiments.
- The counter, register, ROM and comparator stay inline.

## Test plan
- **Reset.** Apply reset with `botoes` = 0000 → `db_contagem` = 0, `db_jogada` = 0, `db_memoria` = 0001, `igual` = 0, `fim` = 0, `jogada_feita` = 0.
- **Single press.** Press `botoes` = 0001 for 5 cycles → `jogada_feita` high for exactly 1 cycle, one edge after the press. Release, then press 0010 → one more pulse.
- **Register and compare.**
  - At address 0: registraR with `botoes` = 0001 → `db_jogada` = 0001 and `igual` = 1 next cycle.
  - Repeat with 0100 → `igual` = 0.
- **Count through the sequence.**
  - Pulse `contaC` 15 times → `db_contagem` = 15, `fim` = 1, `db_memoria` = 0100.
  - One more `contaC` → wraps to 0, `fim` = 0.
- **Priority.**
  - `zeraC` and `contaC` together at count 7 → count 0.
  - `zeraR` and `registraR` together with `botoes` = 1000 → `db_jogada` = 0000.
- **Async reset.** Assert reset between clock edges at count 9 → `db_contagem` = 0 immediately. The next press still yields one pulse.
